muldiv_ctrl: RTL and testbench

- Execute-stage sequencer for the multi-cycle multiply/divide units feeding the HI/LO register pair.
- Accepts one MULT/MULTU/DIV/DIVU per issue and drives the start/signed/annul handshake of the selected unit.
- Holds the E stage stalled until the unit answers, then captures the 64-bit result and issues a single HI/LO write pulse.
- Handles flush (annul), divide-by-zero bypass and a watchdog timeout.

---
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the multi-cycle multiply/divide units.
// Starts the selected unit, stalls E until it answers, then writes HI/LO once.
module muldiv_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_validE,
  input  logic [1:0]  md_opE,
  input  logic        divisor_zeroE,
  input  logic        flushE,
  output logic        mul_start,
  output logic        mul_signed,
  input  logic        mul_ready,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stall_mdE,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          signed_q, signed_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          hilo_we_q, hilo_we_d;
  logic          timeout_q, timeout_d;
  logic          accept, expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      hilo_we_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hilo_we_q <= hilo_we_d;
      timeout_q <= timeout_d;
    end
  end

  // Watchdog fires in the TIMEOUT-th wait cycle unless the unit answers in it.
  assign accept  = (state_q == IDLE) & md_validE & ~flushE & ~rst;
  assign expired = (cnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    hilo_we_d  = 1'b0;
    timeout_d  = timeout_q;
    mul_start  = 1'b0;
    mul_signed = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    stall_mdE  = accept;

    case (state_q)
      IDLE: begin
        if (accept) begin
          signed_d = ~md_opE[0];
          cnt_d    = '0;
          if (!md_opE[1]) begin
            state_d = MUL_WAIT;
          end else if (!divisor_zeroE) begin
            state_d = DIV_WAIT;
          end else begin
            state_d   = DONE;
            hi_d      = '0;
            lo_d      = '0;
            hilo_we_d = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        stall_mdE  = 1'b1;
        mul_start  = ~mul_ready;
        mul_signed = signed_q;
        cnt_d      = cnt_q + 1'b1;
        if (flushE) begin
          state_d = IDLE;
        end else if (mul_ready) begin
          state_d   = DONE;
          hi_d      = mul_result[63:32];
          lo_d      = mul_result[31:0];
          hilo_we_d = 1'b1;
        end else if (expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      DIV_WAIT: begin
        stall_mdE  = 1'b1;
        div_start  = ~div_ready;
        div_signed = signed_q;
        cnt_d      = cnt_q + 1'b1;
        if (flushE) begin
          state_d   = IDLE;
          div_annul = 1'b1;
        end else if (div_ready) begin
          state_d   = DONE;
          hi_d      = div_result[63:32];
          lo_d      = div_result[31:0];
          hilo_we_d = 1'b1;
        end else if (expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          div_annul = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshakes stay quiet for the whole reset cycle.
    if (rst) begin
      mul_start  = 1'b0;
      mul_signed = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_annul  = 1'b0;
      stall_mdE  = 1'b0;
    end
  end

  assign hilo_we     = hilo_we_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed ops, HI/LO writes checked by a scoreboard
// monitor; timing, flush, watchdog and reset checked inline.
module tb_muldiv_ctrl;

  localparam int TO = 40;

  logic        clk;
  logic        rst;
  logic        md_validE;
  logic [1:0]  md_opE;
  logic        divisor_zeroE;
  logic        flushE;
  logic        mul_start;
  logic        mul_signed;
  logic        mul_ready;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stall_mdE;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        timeout_err;

  logic [63:0] expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastHi, lastLo;

  muldiv_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .md_validE(md_validE), .md_opE(md_opE), .divisor_zeroE(divisor_zeroE), .flushE(flushE),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_ready(mul_ready), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_ready(div_ready), .div_result(div_result),
    .stall_mdE(stall_mdE), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every HI/LO write must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (hilo_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected_write: got 0x%0h expected no write", {hi_out, lo_out});
      end else begin
        checkOutput("sb_hilo", {hi_out, lo_out}, expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] op, input logic dz,
                               input int delay, input logic [63:0] res);
    int          waitC;
    int          stallCnt;
    int          weCnt;
    int          startSeen;
    logic        isDivZ;
    logic [63:0] exp;
    isDivZ    = op[1] & dz;
    waitC     = isDivZ ? 0 : delay;
    exp       = isDivZ ? 64'h0 : res;
    stallCnt  = 0;
    weCnt     = 0;
    startSeen = 0;
    expQ.push_back(exp);
    lastHi = exp[63:32];
    lastLo = exp[31:0];
    md_validE     = 1'b1;
    md_opE        = op;
    divisor_zeroE = dz;
    for (int c = 0; c <= waitC + 1; c++) begin
      if (c == 1) begin
        md_validE     = 1'b0;
        divisor_zeroE = 1'b0;
      end
      if (c > 0 && c == waitC) begin
        if (op[1]) begin
          div_ready  = 1'b1;
          div_result = res;
        end else begin
          mul_ready  = 1'b1;
          mul_result = res;
        end
      end
      @(negedge clk);
      if (stall_mdE) stallCnt++;
      if (hilo_we) weCnt++;
      if (mul_start | div_start) startSeen++;
      if (c == 1 && waitC > 1) begin
        checkOutput({name, "_start"}, {62'h0, mul_start, div_start}, op[1] ? 64'd1 : 64'd2);
        checkOutput({name, "_signed"}, {63'h0, op[1] ? div_signed : mul_signed}, {63'h0, ~op[0]});
      end
      if (c > 0 && c == waitC)
        checkOutput({name, "_start_drop"}, {62'h0, mul_start, div_start}, 64'd0);
      if (c == waitC + 1)
        checkOutput({name, "_we_time"}, {63'h0, hilo_we}, 64'd1);
      tick();
      mul_ready = 1'b0;
      div_ready = 1'b0;
    end
    checkOutput({name, "_stall_cycles"}, 64'(stallCnt), 64'(waitC + 1));
    checkOutput({name, "_we_count"}, 64'(weCnt), 64'd1);
    if (isDivZ) checkOutput({name, "_no_start"}, 64'(startSeen), 64'd0);
    @(negedge clk);
    checkOutput({name, "_idle"}, {63'h0, busy}, 64'd0);
    tick();
  endtask

  initial begin
    int annulEarly;
    rst = 1'b1;
    md_validE = 1'b0; md_opE = 2'b00; divisor_zeroE = 1'b0; flushE = 1'b0;
    mul_ready = 1'b0; mul_result = '0; div_ready = 1'b0; div_result = '0;
    lastHi = '0; lastLo = '0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_handshake", {60'h0, mul_start, div_start, div_annul, stall_mdE}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("rst_hilo", {hi_out, lo_out}, 64'd0);
    checkOutput("rst_flags", {61'h0, busy, hilo_we, timeout_err}, 64'd0);
    tick();

    // -7 / 2 signed: quotient -3, remainder -1
    applyStimulus("div_signed", 2'b10, 1'b0, 33, 64'hFFFFFFFF_FFFFFFFD);
    // 0xFFFFFFFF * 2 unsigned = 0x1_FFFFFFFE
    applyStimulus("multu", 2'b01, 1'b0, 3, 64'h00000001_FFFFFFFE);
    applyStimulus("divu_zero", 2'b11, 1'b1, 0, 64'hDEADBEEF_12345678);
    // -3 * 5 signed = -15
    applyStimulus("mult_neg", 2'b00, 1'b0, 1, 64'hFFFFFFFF_FFFFFFF1);
    // 100 / 7 unsigned: quotient 14, remainder 2
    applyStimulus("divu", 2'b11, 1'b0, 5, 64'h00000002_0000000E);

    // Flush five cycles after accept, with ready arriving in the same cycle.
    md_validE = 1'b1; md_opE = 2'b10; divisor_zeroE = 1'b0;
    tick();
    md_validE = 1'b0;
    annulEarly = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (div_annul) annulEarly++;
      tick();
    end
    checkOutput("flush_no_early_annul", 64'(annulEarly), 64'd0);
    flushE = 1'b1; div_ready = 1'b1; div_result = 64'h11112222_33334444;
    @(negedge clk);
    checkOutput("flush_annul", {63'h0, div_annul}, 64'd1);
    tick();
    flushE = 1'b0; div_ready = 1'b0;
    @(negedge clk);
    checkOutput("flush_after", {60'h0, div_annul, busy, stall_mdE, hilo_we}, 64'd0);
    checkOutput("flush_hilo_kept", {hi_out, lo_out}, {lastHi, lastLo});
    tick();
    @(negedge clk);
    checkOutput("flush_no_we", {63'h0, hilo_we}, 64'd0);
    tick();

    // Watchdog: divider never answers.
    md_validE = 1'b1; md_opE = 2'b10; divisor_zeroE = 1'b0;
    tick();
    md_validE = 1'b0;
    annulEarly = 0;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (c == TO - 1) checkOutput("to_not_yet", {63'h0, timeout_err}, 64'd0);
      if (c == TO) checkOutput("to_annul", {62'h0, div_annul, busy}, 64'd3);
      else if (div_annul) annulEarly++;
      tick();
    end
    checkOutput("to_no_early_annul", 64'(annulEarly), 64'd0);
    @(negedge clk);
    checkOutput("to_abort", {61'h0, busy, hilo_we, timeout_err}, 64'd1);
    tick();
    applyStimulus("mult_after_to", 2'b00, 1'b0, 2, 64'd42);
    @(negedge clk);
    checkOutput("to_sticky", {63'h0, timeout_err}, 64'd1);
    tick();

    // Synchronous reset in the middle of a multiply.
    md_validE = 1'b1; md_opE = 2'b00; divisor_zeroE = 1'b0;
    tick();
    md_validE = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_start", {63'h0, mul_start}, 64'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_gated", {62'h0, mul_start, stall_mdE}, 64'd0);
    tick();
    rst = 1'b0;
    mul_ready = 1'b1; mul_result = 64'h0000CAFE_0000BEEF;
    @(negedge clk);
    checkOutput("rstmid_state", {60'h0, busy, stall_mdE, mul_start, timeout_err}, 64'd0);
    checkOutput("rstmid_hilo", {hi_out, lo_out}, 64'd0);
    tick();
    mul_ready = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_late_ready", {62'h0, hilo_we, busy}, 64'd0);
    tick();

    applyStimulus("multu_after_rst", 2'b01, 1'b0, 2, 64'h00000000_00000023);

    repeat (2) tick();
    checkOutput("sb_drain", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
